// File: rtl/spi_flash_read_master.sv
// SPI mode-0 master that fetches one 32-bit little-endian word per request from a serial NOR
// flash using the single-bit READ command, with a request/response handshake on the core side.
module spi_flash_read_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [7:0]  READ_CMD   = 8'h03,
    parameter int unsigned ADDR_WIDTH = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [ADDR_WIDTH-1:0] io_req_bits_addr,
    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [31:0]           io_resp_bits_data,
    output logic                  io_sck,
    output logic                  io_cs,
    output logic                  io_mosi,
    input  logic                  io_miso
);

    localparam int unsigned FrameW = 8 + ADDR_WIDTH + 32;
    localparam int unsigned DivW   = $clog2(2 * CLK_DIV);
    localparam int unsigned BitW   = $clog2(FrameW);

    localparam logic [DivW-1:0] DivHalfM1 = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivFullM1 = DivW'(2 * CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast   = BitW'(FrameW - 1);
    localparam logic [BitW-1:0] RxStart   = BitW'(FrameW - 32);

    typedef enum logic [2:0] {StIdle, StShift, StTail, StGuard, StResp} state_e;

    state_e              r_state, w_state_d;
    logic [DivW-1:0]     r_div, w_div_d;
    logic [BitW-1:0]     r_bit, w_bit_d;
    logic [FrameW-1:0]   r_frame, w_frame_d;
    logic [31:0]         r_rx, w_rx_d;
    logic                r_acked, w_acked_d;
    logic                r_live;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_div   <= '0;
            r_bit   <= '0;
            r_frame <= '0;
            r_rx    <= '0;
            r_acked <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_div   <= w_div_d;
            r_bit   <= w_bit_d;
            r_frame <= w_frame_d;
            r_rx    <= w_rx_d;
            r_acked <= w_acked_d;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_div_d   = r_div;
        w_bit_d   = r_bit;
        w_frame_d = r_frame;
        w_rx_d    = r_rx;
        w_acked_d = r_acked;
        unique case (r_state)
            StIdle: begin
                w_div_d   = '0;
                w_acked_d = 1'b0;
                if (io_req_valid && r_live) begin
                    w_frame_d = {READ_CMD, io_req_bits_addr, 32'h0};
                    w_bit_d   = '0;
                    w_state_d = StShift;
                end
            end
            StShift: begin
                // The edge that ends the low half is the one where SCK rises: sample there.
                if (r_div == DivHalfM1 && r_bit >= RxStart) begin
                    w_rx_d = {r_rx[30:0], io_miso};
                end
                if (r_div == DivFullM1) begin
                    w_div_d   = '0;
                    w_frame_d = r_frame << 1;
                    if (r_bit == BitLast) begin
                        w_state_d = StTail;
                    end else begin
                        w_bit_d = r_bit + 1'b1;
                    end
                end else begin
                    w_div_d = r_div + 1'b1;
                end
            end
            StTail: begin
                if (r_div == DivHalfM1) begin
                    w_div_d   = '0;
                    w_state_d = StGuard;
                end else begin
                    w_div_d = r_div + 1'b1;
                end
            end
            StGuard: begin
                if (io_resp_ready) begin
                    w_acked_d = 1'b1;
                end
                // GUARD always runs its full length so CS-high time is never shortened.
                if (r_div == DivHalfM1) begin
                    w_div_d   = '0;
                    w_state_d = (r_acked || io_resp_ready) ? StIdle : StResp;
                end else begin
                    w_div_d = r_div + 1'b1;
                end
            end
            StResp: begin
                if (io_resp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        io_req_ready      = (r_state == StIdle) && r_live;
        io_cs             = !((r_state == StShift) || (r_state == StTail));
        io_sck            = (r_state == StShift) && (r_div > DivHalfM1);
        io_mosi           = (r_state == StShift) && r_frame[FrameW-1];
        io_resp_valid     = ((r_state == StGuard) && !r_acked) || (r_state == StResp);
        // First received byte lands in the top of r_rx; swap to little-endian word order.
        io_resp_bits_data = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
    end

endmodule

// File: doc/spi_flash_read_master.md
Name: spi_flash_read_master

Overview:
- SPI mode-0 initiator that fetches 32-bit words from a serial NOR flash using the standard READ (0x03) command with a 24-bit byte address.
- Sits between the core's instruction/data fetch path and the board QSPI pins (single-bit MOSI/MISO use of dq_0/dq_1).
- It is the master end of the link whose responder is the simulated SPI flash model used in board-level benches.
- Presents a decoupled request/response interface to the core side.

Parameters:
- CLK_DIV, 4, system clock cycles per SCK half-period; legal values are ≥1.
- READ_CMD, 8'h03, opcode shifted out first.
- ADDR_WIDTH, 24, flash address bits shifted after the opcode.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- io_req_valid  input  1  fetch request valid
- io_req_ready  output  1  block can accept a request
- io_req_bits_addr  input  24  byte address; all bits are sent unmodified
- io_resp_valid  output  1  fetched word available
- io_resp_ready  input  1  consumer accepts the word
- io_resp_bits_data  output  32  fetched word, little-endian
- io_sck  output  1  SPI clock; idles low
- io_cs  output  1  chip select, active low
- io_mosi  output  1  serial data to flash
- io_miso  input  1  serial data from flash

Behaviour:
- Reset (reset=0, asynchronous, effective immediately including mid-transfer):
  - io_cs=1, io_sck=0, io_mosi=0, io_resp_valid=0, io_req_ready=0, io_resp_bits_data=0.
  - FSM returns to IDLE.
  - io_req_ready goes to 1 on the first clock after reset deasserts.
- FSM states: IDLE, SHIFT, TAIL, GUARD, RESP.
- IDLE:
  - io_req_ready=1.
  - On io_req_valid&io_req_ready at edge T, latch a 64-bit shift frame {READ_CMD, addr[23:0], 32'h0}, clear the bit counter, and go to SHIFT.
- SHIFT: 64 bits, MSB first.
  - io_cs=0 from cycle T+1.
  - Each bit lasts 2*CLK_DIV cycles: first CLK_DIV cycles io_sck=0, last CLK_DIV cycles io_sck=1.
  - io_mosi presents the current frame bit from the first cycle of the bit's low half and holds it for the whole bit.
  - io_miso is sampled on the clock edge at which io_sck goes 0→1.
  - Samples are taken only for bits 32..63. Bits 0..31 ignore MISO.
  - After bit 63's high half, go to TAIL.
- TAIL:
  - io_sck=0, io_cs=0, io_mosi=0 for CLK_DIV cycles, then go to GUARD.
  - io_cs is therefore low for exactly 129*CLK_DIV cycles (516 at default).
- Received byte assembly:
  - The 32 sampled bits form bytes b0..b3 in arrival order, each MSB first.
  - io_resp_bits_data = {b3,b2,b1,b0}, matching little-endian word layout in flash.
- GUARD:
  - io_cs=1, io_sck=0.
  - io_resp_valid=1 from the first GUARD cycle; data is stable.
  - Remain for CLK_DIV cycles; this is the minimum CS-high time.
  - If io_resp_ready is seen during GUARD, the handshake completes there and the block stays in GUARD until the count expires, then goes to IDLE.
  - Otherwise go to RESP.
- RESP:
  - io_resp_valid=1 until io_resp_ready. Data is held unchanged under backpressure.
  - On handshake go to IDLE; io_req_ready=1 on the next cycle.
- io_req_ready is 0 in every state except IDLE. Requests are never queued.
- io_resp_valid drops the cycle after the handshake and is never reasserted without a new request.
- Latency at default CLK_DIV=4: request accept at T gives io_resp_valid first high at T+517.
- CLK_DIV=1 is legal: SCK = clock/2, and the TAIL and GUARD phases each last 1 cycle.
- No wrap handling: the address is passed to the flash verbatim. Wrap at 2^24 is the flash's concern.

Test Plan:
- Flash bytes at 0x000000 = 13 05 00 00, request addr 0x000000, resp_ready=1 → MOSI stream 03 00 00 00; io_resp_bits_data=0x00000513; io_cs low exactly 516 cycles; resp_valid first at accept+517.
- Request addr 0x0A5C3C with flash bytes EF BE AD DE there → MOSI bytes 03 0A 5C 3C; data 0xDEADBEEF.
- Backpressure: hold io_resp_ready=0 for 50 cycles after resp_valid → data stable, io_req_ready=0, io_cs=1, no SCK edges; on ready, valid drops the next cycle and req_ready rises.
- Back-to-back: assert req_valid with resp_ready=1 continuously → CS high ≥4 cycles between transactions, and exactly 64 SCK rising edges per CS-low window.
- Reset asserted at bit 20 of SHIFT → io_cs=1 and io_sck=0 asynchronously within the same cycle, resp_valid=0. After release, a fresh request to 0x000000 returns 0x00000513.
- CLK_DIV=1 build: same transaction as the first scenario → io_cs low 129 cycles and correct data.
